// File: rtl/md_unit_param.sv
// Parametrised multiply/divide unit with HI/LO registers, MADD/MSUB accumulation,
// divide-by-zero protection and a same-cycle cancel for exception flush.
module md_unit_param #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [2*WIDTH-1:0]   pend_q, pend_d;

  logic [2*WIDTH-1:0]   acc_cur;
  logic [2*WIDTH-1:0]   prod_s;
  logic [2*WIDTH-1:0]   prod_u;
  logic                 b_zero;
  logic                 b_neg1;
  logic [WIDTH-1:0]     sdiv_b;
  logic [WIDTH-1:0]     udiv_b;
  logic signed [WIDTH-1:0] sq;
  logic signed [WIDTH-1:0] sr;
  logic [WIDTH-1:0]     uq;
  logic [WIDTH-1:0]     ur;
  logic                 accept;

  assign acc_cur = {hi_q, lo_q};
  assign prod_s  = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_u  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Divisors are steered away from 0 and -1 so the divider never sees an
  // undefined or overflowing case; those results are produced explicitly.
  assign b_zero = (b == '0);
  assign b_neg1 = (b == '1);
  assign sdiv_b = (b_zero | b_neg1) ? WIDTH'(1) : b;
  assign udiv_b = b_zero ? WIDTH'(1) : b;
  assign sq     = $signed(a) / $signed(sdiv_b);
  assign sr     = $signed(a) % $signed(sdiv_b);
  assign uq     = a / udiv_b;
  assign ur     = a % udiv_b;

  assign accept = start & ~cancel & (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              state_d = BUSY;
              cnt_d   = CNT_W'(MUL_CYCLES);
              case (op)
                OP_MULT:  pend_d = prod_s;
                OP_MULTU: pend_d = prod_u;
                OP_MADD:  pend_d = acc_cur + prod_s;
                OP_MADDU: pend_d = acc_cur + prod_u;
                OP_MSUB:  pend_d = acc_cur - prod_s;
                default:  pend_d = acc_cur - prod_u;
              endcase
            end
            OP_DIV, OP_DIVU: begin
              state_d = BUSY;
              cnt_d   = CNT_W'(DIV_CYCLES);
              if (b_zero)
                pend_d = acc_cur;
              else if (op == OP_DIVU)
                pend_d = {ur, uq};
              else if (b_neg1)
                pend_d = {{WIDTH{1'b0}}, -a};
              else
                pend_d = {sr, sq};
            end
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          hi_d    = pend_q[2*WIDTH-1:WIDTH];
          lo_d    = pend_q[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit_param.sv
// Directed self-checking bench for md_unit_param with hand-computed HI/LO values.
module tb_md_unit_param;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;

  md_unit_param #(
    .WIDTH(32),
    .MUL_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .cancel(cancel),
    .busy(busy),
    .hi(hi),
    .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one op for a single rising edge, then returns 1 time unit after it.
  task automatic applyStimulus(input logic [3:0] op_v, input logic [31:0] a_v,
                               input logic [31:0] b_v, input logic cancel_v);
    op     = op_v;
    a      = a_v;
    b      = b_v;
    cancel = cancel_v;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cancel = 1'b0;
    op     = 4'd0;
  endtask

  task automatic checkOutput(input string tag, input logic busy_e,
                             input logic [31:0] hi_e, input logic [31:0] lo_e);
    total++;
    assert (busy === busy_e) else begin
      bad++;
      $error("[TB] FAIL %s busy: got %0b want %0b", tag, busy, busy_e);
    end
    total++;
    assert (hi === hi_e) else begin
      bad++;
      $error("[TB] FAIL %s hi: got %08h want %08h", tag, hi, hi_e);
    end
    total++;
    assert (lo === lo_e) else begin
      bad++;
      $error("[TB] FAIL %s lo: got %08h want %08h", tag, lo, lo_e);
    end
  endtask

  // Expects busy with the old HI/LO for n cycles, advancing one edge after each.
  task automatic checkBusyRun(input string tag, input int n,
                              input logic [31:0] hi_o, input logic [31:0] lo_o);
    for (int i = 0; i < n; i++) begin
      checkOutput(tag, 1'b1, hi_o, lo_o);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runMd(input string tag, input logic [3:0] op_v,
                       input logic [31:0] a_v, input logic [31:0] b_v, input int n,
                       input logic [31:0] hi_o, input logic [31:0] lo_o,
                       input logic [31:0] hi_n, input logic [31:0] lo_n);
    applyStimulus(op_v, a_v, b_v, 1'b0);
    checkBusyRun(tag, n, hi_o, lo_o);
    checkOutput(tag, 1'b0, hi_n, lo_n);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 4'd0;
    a      = 32'd0;
    b      = 32'd0;
    cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 32'h0, 32'h0);
    reset = 1'b0;

    $display("[TB] multiply");
    runMd("mult_neg", 4'd1, 32'hFFFFFFFD, 32'd5, 5,
          32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1);
    runMd("multu_max", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,
          32'hFFFFFFFF, 32'hFFFFFFF1, 32'hFFFFFFFE, 32'h00000001);

    $display("[TB] divide");
    runMd("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 10,
          32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runMd("div_minint", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10,
          32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0, 32'h80000000);
    runMd("div_negb", 4'd3, 32'd7, 32'hFFFFFFFE, 10,
          32'h0, 32'h80000000, 32'h00000001, 32'hFFFFFFFD);
    runMd("divu_big", 4'd4, 32'hFFFFFFFF, 32'd2, 10,
          32'h00000001, 32'hFFFFFFFD, 32'h00000001, 32'h7FFFFFFF);

    $display("[TB] move and accumulate");
    applyStimulus(4'd5, 32'd1, 32'd0, 1'b0);
    checkOutput("mthi", 1'b0, 32'h1, 32'h7FFFFFFF);
    applyStimulus(4'd6, 32'd2, 32'd0, 1'b0);
    checkOutput("mtlo", 1'b0, 32'h1, 32'h2);
    runMd("maddu", 4'd8, 32'hFFFFFFFF, 32'd2, 5,
          32'h1, 32'h2, 32'h3, 32'h0);
    runMd("msub", 4'd9, 32'd1, 32'd1, 5,
          32'h3, 32'h0, 32'h2, 32'hFFFFFFFF);
    runMd("madd_neg", 4'd7, 32'hFFFFFFFF, 32'd1, 5,
          32'h2, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE);
    runMd("msubu", 4'd10, 32'hFFFFFFFF, 32'd1, 5,
          32'h2, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFF);

    $display("[TB] divide by zero");
    applyStimulus(4'd6, 32'h55, 32'd0, 1'b0);
    checkOutput("mtlo55", 1'b0, 32'h1, 32'h55);
    runMd("divu_zero", 4'd4, 32'd7, 32'd0, 10,
          32'h1, 32'h55, 32'h1, 32'h55);

    $display("[TB] ignored ops");
    applyStimulus(4'd11, 32'd9, 32'd9, 1'b0);
    checkOutput("op11", 1'b0, 32'h1, 32'h55);
    applyStimulus(4'd1, 32'd9, 32'd9, 1'b1);
    checkOutput("cancel", 1'b0, 32'h1, 32'h55);

    // A DIV presented on the first busy cycle must not disturb the running MULT.
    applyStimulus(4'd1, 32'd2, 32'd3, 1'b0);
    applyStimulus(4'd3, 32'd9, 32'd2, 1'b0);
    checkBusyRun("start_busy", 4, 32'h1, 32'h55);
    checkOutput("start_busy", 1'b0, 32'h0, 32'h6);

    $display("[TB] reset mid-op");
    applyStimulus(4'd1, 32'd7, 32'd7, 1'b0);
    checkBusyRun("rst_mid", 2, 32'h0, 32'h6);
    checkOutput("rst_mid", 1'b1, 32'h0, 32'h6);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_mid_after", 1'b0, 32'h0, 32'h0);
    runMd("mult_recover", 4'd1, 32'd4, 32'd4, 5,
          32'h0, 32'h0, 32'h0, 32'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
